resp_framer: RTL

//  Device-side response framer on the siaminer UART link. Takes found-nonce events from

---
 rtl/resp_framer_if.sv | 36 +++
 rtl/resp_framer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/resp_framer_if.sv
// Bundle of the response framer's producer and UART-side signals.
//
// Handshake: a holding-register transfer happens on a rising clk edge where
// both *_valid and *_ready are high. The producer raises valid with stable
// data and keeps both unchanged until that edge; ready depends only on
// whether the holding register is occupied, never on valid.
// On the UART side new_tx_data is a one-cycle load strobe with tx_data and
// tx_last_byte valid in that same cycle; tx_busy is the transmitter's reply.
interface resp_framer_if;
    logic        nonce_valid;
    logic [31:0] nonce;
    logic        nonce_ready;
    logic        loop_valid;
    logic [7:0]  loop_data;
    logic        loop_ready;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        tx_last_byte;
    logic        frame_active;
    logic [1:0]  state_dbg;

    // Producer / UART / checker side
    modport master (
        output nonce_valid, nonce, loop_valid, loop_data, tx_busy,
        input  nonce_ready, loop_ready, tx_data, new_tx_data, tx_last_byte,
               frame_active, state_dbg
    );

    // Framer side
    modport slave (
        input  nonce_valid, nonce, loop_valid, loop_data, tx_busy,
        output nonce_ready, loop_ready, tx_data, new_tx_data, tx_last_byte,
               frame_active, state_dbg
    );
endinterface

// File: rtl/resp_framer.sv
// Response framer: serialises found-nonce and loop-echo events into
// 0x55, cmd, len, data frames, one byte per UART load strobe.
// Optional macro RESP_XSUM_EN appends an XOR checksum byte (cmd^len^data).
// state_dbg exposes the FSM state: 0 IDLE, 1 SEND, 2 HOLD, 3 WAIT.
module resp_framer #(
    parameter logic [7:0] HEADER    = 8'h55,
    parameter logic [7:0] CMD_NONCE = 8'h00,
    parameter logic [7:0] CMD_LOOP  = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
    resp_framer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2,
        WAIT = 2'd3
    } state_t;

`ifdef RESP_XSUM_EN
    localparam logic [2:0] NONCE_LAST = 3'd7;
    localparam logic [2:0] LOOP_LAST  = 3'd4;
`else
    localparam logic [2:0] NONCE_LAST = 3'd6;
    localparam logic [2:0] LOOP_LAST  = 3'd3;
`endif

    state_t      state, state_d;

    logic        nonce_full;
    logic [31:0] nonce_q;
    logic        loop_full;
    logic [7:0]  loop_q;

    logic        frame_is_nonce;
    logic [31:0] frame_data;
    logic [2:0]  frame_last;
    logic [2:0]  byte_idx;

    logic        load_nonce;
    logic        load_loop;
    logic        strobe;
    logic        idx_inc;
    logic        last;
    logic [7:0]  cur_byte;
    logic [7:0]  cur_cmd;
    logic [7:0]  cur_len;

    assign bus.nonce_ready  = !nonce_full;
    assign bus.loop_ready   = !loop_full;
    assign bus.frame_active = (state != IDLE);
    assign bus.state_dbg    = state;

    assign last    = (byte_idx == frame_last);
    assign cur_cmd = frame_is_nonce ? CMD_NONCE : CMD_LOOP;
    assign cur_len = frame_is_nonce ? 8'd4 : 8'd1;

    // Nonce holding register: set on handshake, freed when its frame loads
    always_ff @(posedge clk) begin
        if (rst) begin
            nonce_full <= 1'b0;
            nonce_q    <= 32'h0;
        end else if (bus.nonce_valid && !nonce_full) begin
            nonce_full <= 1'b1;
            nonce_q    <= bus.nonce;
        end else if (load_nonce) begin
            nonce_full <= 1'b0;
        end
    end

    // Loop holding register: set on handshake, freed when its frame loads
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_full <= 1'b0;
            loop_q    <= 8'h0;
        end else if (bus.loop_valid && !loop_full) begin
            loop_full <= 1'b1;
            loop_q    <= bus.loop_data;
        end else if (load_loop) begin
            loop_full <= 1'b0;
        end
    end

    // Select the frame byte addressed by byte_idx (loop data sits in bits 7:0)
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx)
            3'd0: cur_byte = HEADER;
            3'd1: cur_byte = cur_cmd;
            3'd2: cur_byte = cur_len;
            3'd3: cur_byte = frame_data[7:0];
`ifdef RESP_XSUM_EN
            3'd4: cur_byte = frame_is_nonce ? frame_data[15:8]
                                            : (cur_cmd ^ cur_len ^ frame_data[7:0]);
            3'd7: cur_byte = cur_cmd ^ cur_len ^ frame_data[7:0] ^ frame_data[15:8]
                             ^ frame_data[23:16] ^ frame_data[31:24];
`else
            3'd4: cur_byte = frame_data[15:8];
`endif
            3'd5: cur_byte = frame_data[23:16];
            3'd6: cur_byte = frame_data[31:24];
            default: cur_byte = 8'h00;
        endcase
    end

    // FSM next state: pick a frame, wait for the UART, strobe, guard, wait again
    always_comb begin
        state_d    = state;
        load_nonce = 1'b0;
        load_loop  = 1'b0;
        strobe     = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (nonce_full) begin
                    load_nonce = 1'b1;
                    state_d    = SEND;
                end else if (loop_full) begin
                    load_loop = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!bus.tx_busy) begin
                    strobe  = 1'b1;
                    state_d = HOLD;
                end
            end
            // tx_busy only rises the cycle after the strobe, so skip one look
            HOLD: state_d = WAIT;
            WAIT: begin
                if (!bus.tx_busy) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Frame context, byte index and registered UART outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_is_nonce   <= 1'b0;
            frame_data       <= 32'h0;
            frame_last       <= 3'd0;
            byte_idx         <= 3'd0;
            bus.new_tx_data  <= 1'b0;
            bus.tx_last_byte <= 1'b0;
            bus.tx_data      <= 8'h00;
        end else begin
            if (load_nonce) begin
                frame_is_nonce <= 1'b1;
                frame_data     <= nonce_q;
                frame_last     <= NONCE_LAST;
                byte_idx       <= 3'd0;
            end else if (load_loop) begin
                frame_is_nonce <= 1'b0;
                frame_data     <= {24'h0, loop_q};
                frame_last     <= LOOP_LAST;
                byte_idx       <= 3'd0;
            end else if (idx_inc) begin
                byte_idx <= byte_idx + 3'd1;
            end
            bus.new_tx_data  <= strobe;
            bus.tx_last_byte <= strobe && last;
            if (strobe) bus.tx_data <= cur_byte;
        end
    end

endmodule
